// File: rtl/cpu_consts.sv
// Shared CPU constants: 4-bit ALU function encodings used by the execute stage.
package cpu_consts;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_SLTU = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
endpackage

// File: rtl/execute.sv
// Combinational XLEN-bit ALU. Unassigned function codes produce zero.
module execute
  import cpu_consts::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [3:0]      func_i,
  output logic [XLEN-1:0] res_o
);
  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = opr_b_i[SH_W-1:0];

  always_comb begin
    res_o = '0;
    case (func_i)
      OP_ADD:  res_o = opr_a_i + opr_b_i;
      OP_SUB:  res_o = opr_a_i - opr_b_i;
      OP_SLL:  res_o = opr_a_i << shamt;
      OP_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(opr_a_i) < $signed(opr_b_i))};
      OP_SLTU: res_o = {{(XLEN-1){1'b0}}, (opr_a_i < opr_b_i)};
      OP_XOR:  res_o = opr_a_i ^ opr_b_i;
      OP_SRL:  res_o = opr_a_i >> shamt;
      OP_SRA:  res_o = $signed(opr_a_i) >>> shamt;
      OP_OR:   res_o = opr_a_i | opr_b_i;
      OP_AND:  res_o = opr_a_i & opr_b_i;
      default: res_o = '0;
    endcase
  end
endmodule

// File: rtl/rsp_slot.sv
// One-entry valid/ready response register. Load wins over drain; flush wins over both.
module rsp_slot #(
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the integer pipe (port 0) and the aux unit (port 1),
// with per-port one-entry result slots and a saturating contention counter.
module alu_arbiter
  import cpu_consts::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4,
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [XLEN-1:0]  req0_opr_a_i,
  input  logic [XLEN-1:0]  req0_opr_b_i,
  input  logic [3:0]       req0_func_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [XLEN-1:0]  rsp0_res_o,
  output logic [TAG_W-1:0] rsp0_tag_o,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [XLEN-1:0]  req1_opr_a_i,
  input  logic [XLEN-1:0]  req1_opr_b_i,
  input  logic [3:0]       req1_func_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [XLEN-1:0]  rsp1_res_o,
  output logic [TAG_W-1:0] rsp1_tag_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);
  typedef struct packed {
    logic [XLEN-1:0]  opr_a;
    logic [XLEN-1:0]  opr_b;
    logic [3:0]       func;
    logic [TAG_W-1:0] tag;
  } alu_req_t;

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } alu_rsp_t;

  alu_req_t [1:0] req;
  alu_rsp_t [1:0] rsp;
  logic [1:0]     req_vld, rsp_vld, rsp_rdy, elig, grant;
  alu_req_t       sel_req;
  logic [XLEN-1:0] alu_res;

  logic             last_grant_d, last_grant_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign req[0]     = {req0_opr_a_i, req0_opr_b_i, req0_func_i, req0_tag_i};
  assign req[1]     = {req1_opr_a_i, req1_opr_b_i, req1_func_i, req1_tag_i};
  assign req_vld    = {req1_valid_i, req0_valid_i};
  assign rsp_rdy    = {rsp1_ready_i, rsp0_ready_i};

  // resetn gates eligibility so no ready escapes while reset is held.
  always_comb begin
    for (int p = 0; p < 2; p++)
      elig[p] = req_vld[p] && (!rsp_vld[p] || rsp_rdy[p]) && !flush_i && resetn;
    grant[1] = elig[1] && (!elig[0] || (RR_EN && !last_grant_q));
    grant[0] = elig[0] && !grant[1];
  end

  assign sel_req = grant[1] ? req[1] : req[0];

  execute #(.XLEN(XLEN)) u_alu (
    .opr_a_i (sel_req.opr_a),
    .opr_b_i (sel_req.opr_b),
    .func_i  (sel_req.func),
    .res_o   (alu_res)
  );

  for (genvar p = 0; p < 2; p++) begin : g_slot
    rsp_slot #(.W($bits(alu_rsp_t))) u_slot (
      .clk     (clk),
      .resetn  (resetn),
      .flush_i (flush_i),
      .load_i  (grant[p]),
      .data_i  ({alu_res, sel_req.tag}),
      .ready_i (rsp_rdy[p]),
      .valid_o (rsp_vld[p]),
      .data_o  (rsp[p])
    );
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[0]) last_grant_d = 1'b0;
    if (grant[1]) last_grant_d = 1'b1;
    cnt_d = cnt_q;
    if (&elig && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // last_grant resets to 1 so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req0_ready_o   = grant[0];
  assign req1_ready_o   = grant[1];
  assign rsp0_valid_o   = rsp_vld[0];
  assign rsp1_valid_o   = rsp_vld[1];
  assign rsp0_res_o     = rsp[0].res;
  assign rsp0_tag_o     = rsp[0].tag;
  assign rsp1_res_o     = rsp[1].res;
  assign rsp1_tag_o     = rsp[1].tag;
  assign conflict_cnt_o = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: round-robin instance (u_rr) and a fixed-priority, 2-bit-counter instance (u_fp) on shared inputs.
module tb_alu_arbiter;
  import cpu_consts::*;

  logic clk = 1'b0;
  logic resetn, flush;
  logic v0, v1, rr0, rr1;
  logic [63:0] a0, b0, a1, b1;
  logic [3:0]  f0, f1, t0, t1;

  logic        r_rdy0, r_rdy1, r_vld0, r_vld1;
  logic [63:0] r_res0, r_res1;
  logic [3:0]  r_tag0, r_tag1;
  logic [31:0] r_cnt;
  logic        p_rdy0, p_rdy1, p_vld0, p_vld1;
  logic [63:0] p_res0, p_res1;
  logic [3:0]  p_tag0, p_tag1;
  logic [1:0]  p_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(64), .TAG_W(4), .RR_EN(1'b1), .CNT_W(32)) u_rr (
    .clk(clk), .resetn(resetn), .flush_i(flush),
    .req0_valid_i(v0), .req0_ready_o(r_rdy0), .req0_opr_a_i(a0), .req0_opr_b_i(b0),
    .req0_func_i(f0), .req0_tag_i(t0),
    .rsp0_valid_o(r_vld0), .rsp0_ready_i(rr0), .rsp0_res_o(r_res0), .rsp0_tag_o(r_tag0),
    .req1_valid_i(v1), .req1_ready_o(r_rdy1), .req1_opr_a_i(a1), .req1_opr_b_i(b1),
    .req1_func_i(f1), .req1_tag_i(t1),
    .rsp1_valid_o(r_vld1), .rsp1_ready_i(rr1), .rsp1_res_o(r_res1), .rsp1_tag_o(r_tag1),
    .conflict_cnt_o(r_cnt)
  );

  alu_arbiter #(.XLEN(64), .TAG_W(4), .RR_EN(1'b0), .CNT_W(2)) u_fp (
    .clk(clk), .resetn(resetn), .flush_i(flush),
    .req0_valid_i(v0), .req0_ready_o(p_rdy0), .req0_opr_a_i(a0), .req0_opr_b_i(b0),
    .req0_func_i(f0), .req0_tag_i(t0),
    .rsp0_valid_o(p_vld0), .rsp0_ready_i(rr0), .rsp0_res_o(p_res0), .rsp0_tag_o(p_tag0),
    .req1_valid_i(v1), .req1_ready_o(p_rdy1), .req1_opr_a_i(a1), .req1_opr_b_i(b1),
    .req1_func_i(f1), .req1_tag_i(t1),
    .rsp1_valid_o(p_vld1), .rsp1_ready_i(rr1), .rsp1_res_o(p_res1), .rsp1_tag_o(p_tag1),
    .conflict_cnt_o(p_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1; combinational checks at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; v0 = 0; v1 = 0; rr0 = 0; rr1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; f0 = OP_ADD; f1 = OP_ADD; t0 = '0; t1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    tick();
    resetn = 1;
  endtask

  initial begin
    // Reset state; a valid request during reset must not see ready.
    idle_inputs();
    resetn = 0;
    v0 = 1;
    #2;
    chk("rst_vld0", r_vld0, 0);
    chk("rst_vld1", r_vld1, 0);
    chk("rst_res0", r_res0, 0);
    chk("rst_tag1", r_tag1, 0);
    chk("rst_cnt", r_cnt, 0);
    chk("rst_rdy0", r_rdy0, 0);
    tick();
    idle_inputs();
    resetn = 1;

    // Port 0 only: ADD 5+7 tag 3.
    tick();
    v0 = 1; a0 = 5; b0 = 7; f0 = OP_ADD; t0 = 3; rr0 = 1;
    #1;
    chk("add_rdy0", r_rdy0, 1);
    chk("add_rdy1", r_rdy1, 0);
    tick();
    v0 = 0;
    chk("add_vld0", r_vld0, 1);
    chk("add_res0", r_res0, 64'd12);
    chk("add_tag0", r_tag0, 3);
    chk("add_vld1", r_vld1, 0);
    tick();
    chk("add_drain", r_vld0, 0);

    // Both ports every cycle: RR alternates 0,1,0,1; fixed priority always port 0.
    do_reset();
    v0 = 1; a0 = 1; b0 = 1; f0 = OP_ADD; t0 = 1; rr0 = 1;
    v1 = 1; a1 = 3; b1 = 5; f1 = OP_SUB; t1 = 5; rr1 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_rdy0_%0d", i), r_rdy0, (i % 2 == 0));
      chk($sformatf("rr_rdy1_%0d", i), r_rdy1, (i % 2 == 1));
      chk($sformatf("fp_rdy0_%0d", i), p_rdy0, 1);
      tick();
      if (i == 1) begin
        chk("sub_vld1", r_vld1, 1);
        chk("sub_res1", r_res1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_tag1", r_tag1, 5);
      end
    end
    chk("rr_cnt4", r_cnt, 4);
    chk("fp_cnt_sat", p_cnt, 2'd3);

    // Fixed priority, then slot 0 stalls: port 1 gets through.
    do_reset();
    v0 = 1; a0 = 10; b0 = 20; f0 = OP_ADD; t0 = 2; rr0 = 1;
    v1 = 1; a1 = 7;  b1 = 1;  f1 = OP_XOR; t1 = 4; rr1 = 1;
    tick();
    tick();
    rr0 = 0;
    #1;
    chk("fp_stall_rdy0", p_rdy0, 0);
    chk("fp_stall_rdy1", p_rdy1, 1);
    chk("fp_stall_res0", p_res0, 64'd30);
    tick();
    #1;
    chk("fp_stall2_rdy0", p_rdy0, 0);
    chk("fp_stall2_rdy1", p_rdy1, 1);
    chk("fp_xor_res1", p_res1, 64'd6);
    chk("fp_hold_res0", p_res0, 64'd30);
    tick();
    rr0 = 1;
    #1;
    chk("fp_resume_rdy0", p_rdy0, 1);
    chk("fp_resume_rdy1", p_rdy1, 0);

    // Back-to-back SRA, SLTU, then an unknown func on port 0.
    do_reset();
    v0 = 1; a0 = 64'h8000_0000_0000_0000; b0 = 63; f0 = OP_SRA; t0 = 1; rr0 = 1;
    tick();
    a0 = 1; b0 = 2; f0 = OP_SLTU; t0 = 2;
    #1;
    chk("b2b_rdy0", r_rdy0, 1);
    chk("sra_res0", r_res0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    a0 = 64'h55; b0 = 64'h33; f0 = 4'hF; t0 = 7;
    chk("sltu_vld0", r_vld0, 1);
    chk("sltu_res0", r_res0, 64'd1);
    chk("sltu_tag0", r_tag0, 2);
    tick();
    v0 = 0;
    chk("unk_res0", r_res0, 64'd0);
    chk("unk_tag0", r_tag0, 7);

    // Flush with slot 0 full and a pending request.
    do_reset();
    v0 = 1; a0 = 2; b0 = 3; f0 = OP_ADD; t0 = 1; rr0 = 0;
    tick();
    flush = 1; a0 = 4; b0 = 4; t0 = 9;
    #1;
    chk("fl_vld0_pre", r_vld0, 1);
    chk("fl_rdy0", r_rdy0, 0);
    tick();
    flush = 0;
    chk("fl_vld0", r_vld0, 0);
    #1;
    chk("fl_after_rdy0", r_rdy0, 1);
    tick();
    v0 = 0;
    chk("fl_new_vld0", r_vld0, 1);
    chk("fl_new_res0", r_res0, 64'd8);
    chk("fl_new_tag0", r_tag0, 9);

    // Async reset with both slots full; first conflict after release goes to port 0.
    do_reset();
    v0 = 1; a0 = 1; b0 = 2; f0 = OP_ADD; t0 = 1;
    v1 = 1; a1 = 3; b1 = 4; f1 = OP_ADD; t1 = 2;
    tick();
    tick();
    chk("mid_vld0", r_vld0, 1);
    chk("mid_vld1", r_vld1, 1);
    chk("mid_cnt", r_cnt, 1);
    chk("mid_res1", r_res1, 64'd7);
    #2;
    resetn = 0;
    #1;
    chk("ar_vld0", r_vld0, 0);
    chk("ar_vld1", r_vld1, 0);
    chk("ar_cnt", r_cnt, 0);
    chk("ar_rdy1", r_rdy1, 0);
    tick();
    resetn = 1; rr0 = 1; rr1 = 1;
    #1;
    chk("ar_first_rdy0", r_rdy0, 1);
    chk("ar_first_rdy1", r_rdy1, 0);
    tick();
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
